// File: rtl/pll_reset_sequencer_pkg.sv
// rtl/pll_reset_sequencer_pkg.sv - shared state encodings and default constants for the reset sequencer
//
// Purpose : state encodings, default timing constants and a small helper
//           shared by the PLL reset sequencer and anything decoding seq_state.
// Ports   : none (package).
package pll_reset_sequencer_pkg;

    localparam logic [1:0] SEQ_S_WAIT   = 2'd0;
    localparam logic [1:0] SEQ_S_STAB   = 2'd1;
    localparam logic [1:0] SEQ_S_PERIPH = 2'd2;
    localparam logic [1:0] SEQ_S_RUN    = 2'd3;

    localparam int SEQ_SYNC_STAGES   = 2;
    localparam int SEQ_STABLE_CYCLES = 1024;
    localparam int SEQ_CORE_DELAY    = 16;
    localparam int SEQ_DEBOUNCE      = 4;

    typedef enum logic [1:0] {
        S_WAIT   = SEQ_S_WAIT,
        S_STAB   = SEQ_S_STAB,
        S_PERIPH = SEQ_S_PERIPH,
        S_RUN    = SEQ_S_RUN
    } seq_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_ff.sv
// rtl/pll_reset_sequencer_sync_ff.sv - N-stage single-bit synchroniser with synchronous clear
//
// Purpose : brings an asynchronous single-bit input into the clk domain.
//           Reusable for buttons, UART rx and similar inputs.
// Ports   : clk - destination clock
//           clr - synchronous active-high clear of every stage
//           d   - asynchronous input
//           q   - synchronised output (last stage)
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Stage 0 takes the raw input; each later stage copies the previous one.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - staged peripheral/core reset release gated on a stable PLL lock
//
// Purpose : waits for a stable synchronised PLL lock, releases peripherals,
//           then the core after a delay; returns to reset on a debounced
//           lock loss in RUN and counts those losses.
// Ports   : clk             - PLL output clock, the only clock
//           reset           - synchronous active-high reset
//           pll_locked      - PLL lock, asynchronous to clk
//           periph_rst      - active-high peripheral reset (registered)
//           core_rst        - active-high core reset (registered)
//           ready           - high while in RUN (registered)
//           lock_loss_count - saturating count of RUN-state lock losses
//           seq_state       - current state, for debug
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES   = SEQ_SYNC_STAGES,
    parameter int STABLE_CYCLES = SEQ_STABLE_CYCLES,
    parameter int CORE_DELAY    = SEQ_CORE_DELAY,
    parameter int DEBOUNCE      = SEQ_DEBOUNCE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    output logic       periph_rst,
    output logic       core_rst,
    output logic       ready,
    output logic [7:0] lock_loss_count,
    output logic [1:0] seq_state
);

    localparam int CNT_W  = $clog2(max_int(STABLE_CYCLES, CORE_DELAY) + 1);
    localparam int LCNT_W = $clog2(DEBOUNCE + 1);

    localparam logic [CNT_W-1:0]  STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CORE_LAST = CNT_W'(CORE_DELAY - 1);
    localparam logic [LCNT_W-1:0] LOSS_LAST = LCNT_W'(DEBOUNCE - 1);

    logic lock_s;

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic [7:0]        llc_q, llc_d;
    logic              periph_rst_q, periph_rst_d;
    logic              core_rst_q, core_rst_d;
    logic              ready_q, ready_d;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk),
        .clr (reset),
        .d   (pll_locked),
        .q   (lock_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lcnt_d  = lcnt_q;
        llc_d   = llc_q;

        case (state_q)
            S_WAIT: begin
                if (lock_s) begin
                    state_d = S_STAB;
                    cnt_d   = '0;
                end
            end
            S_STAB: begin
                // Any drop before the peripherals are released simply
                // restarts the wait; it is not a loss event.
                if (!lock_s) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == STAB_LAST) begin
                    state_d = S_PERIPH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PERIPH: begin
                if (!lock_s) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == CORE_LAST) begin
                    state_d = S_RUN;
                    lcnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                // Only DEBOUNCE consecutive low samples count; any high
                // sample in between restarts the debounce.
                if (lock_s) begin
                    lcnt_d = '0;
                end else if (lcnt_q == LOSS_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    lcnt_d  = '0;
                    if (llc_q != 8'hFF) begin
                        llc_d = llc_q + 8'd1;
                    end
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_WAIT;
                cnt_d   = '0;
                lcnt_d  = '0;
            end
        endcase

        // Outputs decode the next state so they move on the same edge.
        periph_rst_d = !((state_d == S_PERIPH) || (state_d == S_RUN));
        core_rst_d   = (state_d != S_RUN);
        ready_d      = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_WAIT;
            cnt_q        <= '0;
            lcnt_q       <= '0;
            llc_q        <= '0;
            periph_rst_q <= 1'b1;
            core_rst_q   <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lcnt_q       <= lcnt_d;
            llc_q        <= llc_d;
            periph_rst_q <= periph_rst_d;
            core_rst_q   <= core_rst_d;
            ready_q      <= ready_d;
        end
    end

    assign periph_rst      = periph_rst_q;
    assign core_rst        = core_rst_q;
    assign ready           = ready_q;
    assign lock_loss_count = llc_q;
    assign seq_state       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       periph_rst, core_rst, ready;
    logic [7:0] lock_loss_count;
    logic [1:0] seq_state;

    logic       reset2 = 1'b1;
    logic       pll_locked2 = 1'b0;
    logic       periph_rst2, core_rst2, ready2;
    logic [7:0] lock_loss_count2;
    logic [1:0] seq_state2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pll_reset_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .pll_locked      (pll_locked),
        .periph_rst      (periph_rst),
        .core_rst        (core_rst),
        .ready           (ready),
        .lock_loss_count (lock_loss_count),
        .seq_state       (seq_state)
    );

    pll_reset_sequencer #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (2),
        .CORE_DELAY    (1),
        .DEBOUNCE      (1)
    ) dut_small (
        .clk             (clk),
        .reset           (reset2),
        .pll_locked      (pll_locked2),
        .periph_rst      (periph_rst2),
        .core_rst        (core_rst2),
        .ready           (ready2),
        .lock_loss_count (lock_loss_count2),
        .seq_state       (seq_state2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_and_startup();
        int pf, cf, rr;
        logic [1:0] s2, s3, s1026, s1027, s1042, s1043;
        reset = 1'b1; pll_locked = 1'b0;
        repeat (3) step();
        tests++;
        if ({seq_state, periph_rst, core_rst, ready, lock_loss_count} !== {2'd0, 1'b1, 1'b1, 1'b0, 8'd0}) begin
            fails++;
            $display("FAIL reset_state: got st=%0d prst=%b crst=%b rdy=%b cnt=%0d want 0 1 1 0 0",
                     seq_state, periph_rst, core_rst, ready, lock_loss_count);
        end
        reset = 1'b0; pll_locked = 1'b1;
        pf = 0; cf = 0; rr = 0;
        s2 = 'x; s3 = 'x; s1026 = 'x; s1027 = 'x; s1042 = 'x; s1043 = 'x;
        for (int e = 1; e <= 1060; e++) begin
            step();
            if (!periph_rst && pf == 0) pf = e;
            if (!core_rst && cf == 0) cf = e;
            if (ready && rr == 0) rr = e;
            if (e == 2)    s2 = seq_state;
            if (e == 3)    s3 = seq_state;
            if (e == 1026) s1026 = seq_state;
            if (e == 1027) s1027 = seq_state;
            if (e == 1042) s1042 = seq_state;
            if (e == 1043) s1043 = seq_state;
        end
        tests++; if (pf !== 1027) begin fails++; $display("FAIL startup_periph_edge: got %0d want 1027", pf); end
        tests++; if (cf !== 1043) begin fails++; $display("FAIL startup_core_edge: got %0d want 1043", cf); end
        tests++; if (rr !== 1043) begin fails++; $display("FAIL startup_ready_edge: got %0d want 1043", rr); end
        tests++; if (s2 !== 2'd0) begin fails++; $display("FAIL state_e2: got %0d want 0", s2); end
        tests++; if (s3 !== 2'd1) begin fails++; $display("FAIL state_e3: got %0d want 1", s3); end
        tests++; if (s1026 !== 2'd1) begin fails++; $display("FAIL state_e1026: got %0d want 1", s1026); end
        tests++; if (s1027 !== 2'd2) begin fails++; $display("FAIL state_e1027: got %0d want 2", s1027); end
        tests++; if (s1042 !== 2'd2) begin fails++; $display("FAIL state_e1042: got %0d want 2", s1042); end
        tests++; if (s1043 !== 2'd3) begin fails++; $display("FAIL state_e1043: got %0d want 3", s1043); end
        tests++; if (lock_loss_count !== 8'd0) begin fails++; $display("FAIL startup_count: got %0d want 0", lock_loss_count); end
    endtask

    task automatic test_stab_drop();
        int pf, cf;
        logic [1:0] s501, s502;
        reset = 1'b1; pll_locked = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        pf = 0; cf = 0; s501 = 'x; s502 = 'x;
        for (int e = 1; e <= 1570; e++) begin
            pll_locked = (e >= 500 && e < 510) ? 1'b0 : 1'b1;
            step();
            if (!periph_rst && pf == 0) pf = e;
            if (!core_rst && cf == 0) cf = e;
            if (e == 501) s501 = seq_state;
            if (e == 502) s502 = seq_state;
        end
        tests++; if (s501 !== 2'd1) begin fails++; $display("FAIL stab_drop_e501: got %0d want 1", s501); end
        tests++; if (s502 !== 2'd0) begin fails++; $display("FAIL stab_drop_e502: got %0d want 0", s502); end
        tests++; if (pf !== 1536) begin fails++; $display("FAIL stab_restart_periph: got %0d want 1536", pf); end
        tests++; if (cf !== 1552) begin fails++; $display("FAIL stab_restart_core: got %0d want 1552", cf); end
        tests++; if (lock_loss_count !== 8'd0) begin fails++; $display("FAIL stab_drop_count: got %0d want 0", lock_loss_count); end
    endtask

    task automatic test_run_debounce();
        int bad, rf;
        logic [3:0] o7, o8;
        bad = 0;
        for (int e = 1; e <= 20; e++) begin
            pll_locked = (e >= 3 && e <= 5) ? 1'b0 : 1'b1;
            step();
            if (!ready || periph_rst || core_rst || seq_state != 2'd3) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL short_pulse: got %0d disturbed edges want 0", bad); end
        tests++; if (lock_loss_count !== 8'd0) begin fails++; $display("FAIL short_pulse_count: got %0d want 0", lock_loss_count); end
        rf = 0; o7 = 'x; o8 = 'x;
        for (int e = 1; e <= 12; e++) begin
            pll_locked = (e >= 3 && e <= 6) ? 1'b0 : 1'b1;
            step();
            if (!ready && rf == 0) rf = e;
            if (e == 7) o7 = {seq_state, periph_rst, core_rst};
            if (e == 8) o8 = {seq_state, periph_rst, core_rst};
        end
        tests++; if (rf !== 8) begin fails++; $display("FAIL loss_edge: got %0d want 8", rf); end
        tests++; if (o7 !== 4'b1100) begin fails++; $display("FAIL loss_e7: got %b want 1100", o7); end
        tests++; if (o8 !== 4'b0011) begin fails++; $display("FAIL loss_e8: got %b want 0011", o8); end
        tests++; if (lock_loss_count !== 8'd1) begin fails++; $display("FAIL loss_count: got %0d want 1", lock_loss_count); end
    endtask

    task automatic bring_to_run(input string tag);
        int n;
        pll_locked = 1'b1;
        n = 0;
        while (!ready && n < 1200) begin step(); n++; end
        tests++;
        if (!ready) begin fails++; $display("FAIL %s_run_timeout: got ready=%b want 1", tag, ready); end
    endtask

    task automatic lose_lock(input string tag);
        int n;
        pll_locked = 1'b0;
        n = 0;
        while (ready && n < 20) begin step(); n++; end
        tests++;
        if (ready) begin fails++; $display("FAIL %s_loss_timeout: got ready=%b want 0", tag, ready); end
    endtask

    task automatic test_reset_mid_run();
        int pf;
        bring_to_run("m1");
        lose_lock("m1");
        bring_to_run("m2");
        lose_lock("m2");
        bring_to_run("m3");
        tests++; if (lock_loss_count !== 8'd3) begin fails++; $display("FAIL mid_pre_count: got %0d want 3", lock_loss_count); end
        reset = 1'b1;
        step();
        tests++;
        if ({seq_state, periph_rst, core_rst, ready, lock_loss_count} !== {2'd0, 1'b1, 1'b1, 1'b0, 8'd0}) begin
            fails++;
            $display("FAIL mid_reset_state: got st=%0d prst=%b crst=%b rdy=%b cnt=%0d want 0 1 1 0 0",
                     seq_state, periph_rst, core_rst, ready, lock_loss_count);
        end
        reset = 1'b0;
        pf = 0;
        for (int e = 1; e <= 1030; e++) begin
            step();
            if (!periph_rst && pf == 0) pf = e;
        end
        tests++; if (pf !== 1027) begin fails++; $display("FAIL mid_restart_periph: got %0d want 1027", pf); end
    endtask

    task automatic test_toggle_lock();
        int bad;
        logic saw_stab;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bad = 0; saw_stab = 1'b0;
        for (int e = 1; e <= 200; e++) begin
            pll_locked = e[0];
            step();
            if (seq_state > 2'd1 || !periph_rst || !core_rst) bad++;
            if (seq_state == 2'd1) saw_stab = 1'b1;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL toggle_outputs: got %0d bad edges want 0", bad); end
        tests++; if (saw_stab !== 1'b1) begin fails++; $display("FAIL toggle_stab_seen: got %b want 1", saw_stab); end
    endtask

    task automatic test_saturation();
        int n, want;
        reset2 = 1'b1;
        step();
        reset2 = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            pll_locked2 = 1'b1;
            n = 0;
            while (!ready2 && n < 20) begin step(); n++; end
            pll_locked2 = 1'b0;
            n = 0;
            while (ready2 && n < 20) begin step(); n++; end
            want = (i > 255) ? 255 : i;
            tests++;
            if (lock_loss_count2 !== 8'(want)) begin
                fails++;
                $display("FAIL sat_count_%0d: got %0d want %0d", i, lock_loss_count2, want);
            end
        end
        repeat (5) step();
        tests++; if (lock_loss_count2 !== 8'd255) begin fails++; $display("FAIL sat_hold: got %0d want 255", lock_loss_count2); end
    endtask

    initial begin
        test_reset_and_startup();
        test_stab_drop();
        test_run_debounce();
        test_reset_mid_run();
        test_toggle_lock();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
